cpu_branch_predictor: RTL and testbench

CPU_BRANCH_PREDICTOR -- requirements
Module: cpu_branch_predictor

---
 rtl/cpu_bp_pkg.sv | 38 +++
 rtl/cpu_bp_counter.sv | 12 +
 rtl/cpu_branch_predictor.sv | 157 +++++++++++++++
 tb/tb_cpu_branch_predictor.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bp_pkg.sv
// Shared types for the branch predictor: counter encoding, table entry layout,
// controller states and the saturating counter step.
package cpu_bp_pkg;

   // Widest tag needed: smallest table (4 entries) leaves pc[31:4].
   localparam int unsigned TagMaxW = 28;

   typedef enum logic [1:0] {
      CntStrongNt = 2'b00,
      CntWeakNt   = 2'b01,
      CntWeakT    = 2'b10,
      CntStrongT  = 2'b11
   } cnt_e;

   typedef enum logic {
      StInit,
      StRun
   } state_e;

   typedef struct packed {
      logic               valid;
      logic [TagMaxW-1:0] tag;
      logic [31:0]        target;
      cnt_e               cnt;
   } bp_entry_t;

   function automatic cnt_e cnt_step(input cnt_e cur, input logic taken);
      cnt_e nxt;
      case (cur)
         CntStrongNt: nxt = taken ? CntWeakNt  : CntStrongNt;
         CntWeakNt:   nxt = taken ? CntWeakT   : CntStrongNt;
         CntWeakT:    nxt = taken ? CntStrongT : CntWeakNt;
         default:     nxt = taken ? CntStrongT : CntWeakT;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/cpu_bp_counter.sv
// Two-bit saturating direction counter update.
module cpu_bp_counter
   import cpu_bp_pkg::*;
(
   input  cnt_e cnt_i,
   input  logic taken_i,
   output cnt_e cnt_o
);

   assign cnt_o = cnt_step(cnt_i, taken_i);

endmodule

// File: rtl/cpu_branch_predictor.sv
// Direct-mapped branch predictor with 2-bit counters and a target per entry.
// Table valid bits are swept clear after reset before lookups are accepted.
module cpu_branch_predictor
   import cpu_bp_pkg::*;
#(
   parameter int unsigned ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pred_valid,
   input  logic [31:0] pred_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   output logic        ready,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_pred_taken,
   input  logic [31:0] upd_pred_target,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   localparam int unsigned IdxW = $clog2(ENTRIES);

   state_e            state_q, state_d;
   logic [IdxW-1:0]   init_idx_q, init_idx_d;
   logic              init_we;
   logic              run;

   bp_entry_t         table_q [ENTRIES];

   logic [IdxW-1:0]    pred_idx, upd_idx;
   logic [TagMaxW-1:0] pred_tag, upd_tag;
   bp_entry_t          pred_ent, upd_ent, upd_wdata;
   logic               pred_hit, upd_hit, upd_we, mispredict;
   cnt_e               cnt_next;

   logic        pred_taken_q, pred_taken_d;
   logic [31:0] pred_target_q, pred_target_d;
   logic        redirect_valid_q, redirect_valid_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;

   // Controller: state register / next state / outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StInit;
         init_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         init_idx_q <= init_idx_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_idx_d = init_idx_q;
      case (state_q)
         StInit: begin
            init_idx_d = init_idx_q + IdxW'(1);
            if (init_idx_q == IdxW'(ENTRIES - 1)) state_d = StRun;
         end
         StRun: state_d = StRun;
      endcase
   end

   always_comb begin
      run     = (state_q == StRun);
      ready   = run;
      init_we = (state_q == StInit) && !rst;
   end

   // Lookup
   assign pred_idx = pred_pc[IdxW+1:2];
   assign pred_tag = TagMaxW'(pred_pc >> (IdxW + 2));
   assign pred_ent = table_q[pred_idx];
   assign pred_hit = pred_ent.valid && (pred_ent.tag == pred_tag);

   always_comb begin
      pred_taken_d  = 1'b0;
      pred_target_d = '0;
      if (run && pred_valid) begin
         if (pred_hit && (pred_ent.cnt inside {CntWeakT, CntStrongT})) begin
            pred_taken_d  = 1'b1;
            pred_target_d = pred_ent.target;
         end else begin
            pred_target_d = pred_pc + 32'd4;
         end
      end
   end

   // Update
   assign upd_idx = upd_pc[IdxW+1:2];
   assign upd_tag = TagMaxW'(upd_pc >> (IdxW + 2));
   assign upd_ent = table_q[upd_idx];
   assign upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);

   cpu_bp_counter u_counter (
      .cnt_i   (upd_ent.cnt),
      .taken_i (upd_taken),
      .cnt_o   (cnt_next)
   );

   always_comb begin
      upd_we    = 1'b0;
      upd_wdata = upd_ent;
      if (run && upd_valid && !rst) begin
         if (upd_hit) begin
            upd_we        = 1'b1;
            upd_wdata.cnt = cnt_next;
            if (upd_taken) upd_wdata.target = upd_target;
         end else if (upd_taken) begin
            upd_we    = 1'b1;
            upd_wdata = '{valid: 1'b1, tag: upd_tag, target: upd_target, cnt: CntWeakT};
         end
      end
   end

   // Table is not reset; validity is owned by the init sweep.
   always_ff @(posedge clk) begin
      if (init_we) begin
         table_q[init_idx_q].valid <= 1'b0;
      end else if (upd_we) begin
         table_q[upd_idx] <= upd_wdata;
      end
   end

   // Redirect
   always_comb begin
      mispredict = (upd_taken != upd_pred_taken) ||
                   (upd_taken && (upd_target != upd_pred_target));
      redirect_valid_d = run && upd_valid && mispredict;
      redirect_pc_d    = '0;
      if (redirect_valid_d) redirect_pc_d = upd_taken ? upd_target : upd_pc + 32'd4;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pred_taken_q     <= 1'b0;
         pred_target_q    <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         pred_taken_q     <= pred_taken_d;
         pred_target_q    <= pred_target_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   assign pred_taken     = pred_taken_q;
   assign pred_target    = pred_target_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_cpu_branch_predictor.sv
// Directed bench for cpu_branch_predictor with hand-computed expectations.
module tb_cpu_branch_predictor;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pred_valid = 1'b0;
   logic [31:0] pred_pc = '0;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ready;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_pc = '0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_target = '0;
   logic        upd_pred_taken = 1'b0;
   logic [31:0] upd_pred_target = '0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   cpu_branch_predictor #(.ENTRIES(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .pred_valid      (pred_valid),
      .pred_pc         (pred_pc),
      .pred_taken      (pred_taken),
      .pred_target     (pred_target),
      .ready           (ready),
      .upd_valid       (upd_valid),
      .upd_pc          (upd_pc),
      .upd_taken       (upd_taken),
      .upd_target      (upd_target),
      .upd_pred_taken  (upd_pred_taken),
      .upd_pred_target (upd_pred_target),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
      upd_valid       = 1'b1;
      upd_pc          = pc;
      upd_taken       = tk;
      upd_target      = tgt;
      upd_pred_taken  = ptk;
      upd_pred_target = ptgt;
   endtask

   task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                            input logic ptk, input logic [31:0] ptgt);
      set_upd(pc, tk, tgt, ptk, ptgt);
      tick();
      upd_valid = 1'b0;
   endtask

   task automatic do_lookup(input logic [31:0] pc);
      pred_valid = 1'b1;
      pred_pc    = pc;
      tick();
      pred_valid = 1'b0;
   endtask

   task automatic test_reset();
      set_upd(32'h500, 1'b1, 32'h40, 1'b0, 32'h0);
      pred_valid = 1'b1;
      pred_pc    = 32'h500;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_pred: got %b/%h want 0/00000000", pred_taken, pred_target);
      end
      vectors++;
      if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_redirect: got %b/%h want 0/00000000", redirect_valid, redirect_pc);
      end
      for (int k = 0; k < 16; k++) begin
         vectors++;
         if (ready !== 1'b0 || redirect_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL init_cycle%0d: ready=%b redirect=%b want 0/0", k + 1, ready,
                     redirect_valid);
         end
         tick();
      end
      upd_valid  = 1'b0;
      pred_valid = 1'b0;
      vectors++;
      if (ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_cycle17: got %b want 1", ready);
      end
      vectors++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h0 || redirect_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL init_ignores: got %b/%h/%b want 0/00000000/0", pred_taken, pred_target,
                  redirect_valid);
      end
   endtask

   task automatic test_ignored_init();
      do_lookup(32'h500);
      vectors++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h504) begin
         miscompares++;
         $display("FAIL no_alloc_in_init: got %b/%h want 0/00000504", pred_taken, pred_target);
      end
   endtask

   task automatic test_alloc_predict();
      do_update(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
      vectors++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80) begin
         miscompares++;
         $display("FAIL alloc_redirect: got %b/%h want 1/00000080", redirect_valid, redirect_pc);
      end
      do_lookup(32'h100);
      vectors++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
         miscompares++;
         $display("FAIL alloc_lookup: got %b/%h want 1/00000080", pred_taken, pred_target);
      end
      vectors++;
      if (redirect_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL redirect_pulse: got %b want 0", redirect_valid);
      end
      tick();
      vectors++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
         miscompares++;
         $display("FAIL idle_pred: got %b/%h want 0/00000000", pred_taken, pred_target);
      end
   endtask

   task automatic test_alias();
      do_lookup(32'h140);
      vectors++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h144) begin
         miscompares++;
         $display("FAIL alias: got %b/%h want 0/00000144", pred_taken, pred_target);
      end
   endtask

   task automatic test_counter();
      for (int i = 0; i < 4; i++) do_update(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
      do_lookup(32'h100);
      vectors++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
         miscompares++;
         $display("FAIL decay_to_snt: got %b/%h want 0/00000104", pred_taken, pred_target);
      end
      do_update(32'h100, 1'b1, 32'h90, 1'b0, 32'h0);
      do_lookup(32'h100);
      vectors++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
         miscompares++;
         $display("FAIL low_saturate: got %b/%h want 0/00000104", pred_taken, pred_target);
      end
      do_update(32'h100, 1'b1, 32'h90, 1'b0, 32'h0);
      do_lookup(32'h100);
      vectors++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h90) begin
         miscompares++;
         $display("FAIL weak_taken_target: got %b/%h want 1/00000090", pred_taken, pred_target);
      end
      do_update(32'h100, 1'b1, 32'h90, 1'b1, 32'h90);
      do_update(32'h100, 1'b1, 32'h90, 1'b1, 32'h90);
      do_update(32'h100, 1'b0, 32'h0, 1'b1, 32'h90);
      do_lookup(32'h100);
      vectors++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h90) begin
         miscompares++;
         $display("FAIL high_saturate: got %b/%h want 1/00000090", pred_taken, pred_target);
      end
   endtask

   task automatic test_redirect();
      do_update(32'h200, 1'b0, 32'h0, 1'b1, 32'h0);
      vectors++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h204) begin
         miscompares++;
         $display("FAIL redirect_nt: got %b/%h want 1/00000204", redirect_valid, redirect_pc);
      end
      tick();
      vectors++;
      if (redirect_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL redirect_drop: got %b want 0", redirect_valid);
      end
      do_update(32'h200, 1'b0, 32'h0, 1'b0, 32'h0);
      vectors++;
      if (redirect_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL correct_no_redirect: got %b want 0", redirect_valid);
      end
      do_update(32'h204, 1'b1, 32'h400, 1'b1, 32'h300);
      vectors++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h400) begin
         miscompares++;
         $display("FAIL target_mismatch: got %b/%h want 1/00000400", redirect_valid, redirect_pc);
      end
      do_update(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0);
      vectors++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0) begin
         miscompares++;
         $display("FAIL pc_wrap: got %b/%h want 1/00000000", redirect_valid, redirect_pc);
      end
   endtask

   task automatic test_same_cycle();
      set_upd(32'h300, 1'b1, 32'h700, 1'b1, 32'h700);
      pred_valid = 1'b1;
      pred_pc    = 32'h300;
      tick();
      upd_valid  = 1'b0;
      pred_valid = 1'b0;
      vectors++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h304 || redirect_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rbw_lookup: got %b/%h/%b want 0/00000304/0", pred_taken, pred_target,
                  redirect_valid);
      end
      do_lookup(32'h300);
      vectors++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h700) begin
         miscompares++;
         $display("FAIL rbw_after: got %b/%h want 1/00000700", pred_taken, pred_target);
      end
   endtask

   task automatic test_reset_mid_run();
      set_upd(32'h600, 1'b1, 32'h50, 1'b0, 32'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      upd_valid = 1'b0;
      vectors++;
      if (ready !== 1'b0 || redirect_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL midrun_reset: ready=%b redirect=%b want 0/0", ready, redirect_valid);
      end
      for (int k = 0; k < 16; k++) tick();
      vectors++;
      if (ready !== 1'b1) begin
         miscompares++;
         $display("FAIL midrun_ready: got %b want 1", ready);
      end
      do_lookup(32'h300);
      vectors++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h304) begin
         miscompares++;
         $display("FAIL midrun_cleared: got %b/%h want 0/00000304", pred_taken, pred_target);
      end
   endtask

   initial begin
      test_reset();
      test_ignored_init();
      test_alloc_predict();
      test_alias();
      test_counter();
      test_redirect();
      test_same_cycle();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
